// File: rtl/fft_seq_pkg.sv
// -----------------------------------------------------------------------------
// fft_seq_pkg
//   Shared types and helpers for the FFT stage sequencer.
//   - seq_state_e : sequencer state encoding
//   - clamp_log2n : folds a requested transform length into the supported range
//   - bitrev      : reverses the low L bits of an address (output reordering)
// -----------------------------------------------------------------------------
package fft_seq_pkg;

   // Working width of the helper functions; callers zero-extend/truncate.
   localparam int SEQ_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COMPUTE = 3'd1,
      ST_GAP     = 3'd2,
      ST_FINISH  = 3'd3,
      ST_OUTPUT  = 3'd4
   } seq_state_e;

   // A zero-length request still runs one stage; oversize requests saturate.
   function automatic logic [3:0] clamp_log2n(input logic [3:0] v, input logic [3:0] max_l);
      if (v == 4'd0) begin
         return 4'd1;
      end else if (v > max_l) begin
         return max_l;
      end else begin
         return v;
      end
   endfunction

   // Reverse bits [l-1:0] of x; bits at and above l come back as zero.
   function automatic logic [SEQ_W-1:0] bitrev(input logic [SEQ_W-1:0] x, input logic [3:0] l);
      logic [SEQ_W-1:0] r;
      r = '0;
      for (int i = 0; i < SEQ_W; i++) begin
         if (i < int'(l)) begin
            r[int'(l) - 1 - i] = x[i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// -----------------------------------------------------------------------------
// fft_stage_sequencer_if
//   Control/address bundle between the FFT sequencer and its surroundings.
//   master : controller side (drives start/log2n/abort/en_out[/inverse])
//   slave  : sequencer side (drives RAM/twiddle addresses, enables, status)
//   Optional macro FFT_SEQ_INVERSE_EN adds the 'inverse' request bit.
// -----------------------------------------------------------------------------
interface fft_stage_sequencer_if #(
   parameter int MAX_LOG2N = 10
);
   logic                 start;
   logic [3:0]           log2n;
   logic                 abort;
   logic                 en_out;
`ifdef FFT_SEQ_INVERSE_EN
   logic                 inverse;
`endif
   logic [MAX_LOG2N-1:0] rd_ptr;
   logic [MAX_LOG2N-1:0] rd_ptr_angle;
   logic                 en_rd;
   logic                 en_modify_tw;
   logic                 en_modify;
   logic [3:0]           stage;
   logic                 busy;
   logic                 finish_FFT;
   logic                 out_valid;
   logic                 done_o;

   modport master (
`ifdef FFT_SEQ_INVERSE_EN
      output inverse,
`endif
      output start, log2n, abort, en_out,
      input  rd_ptr, rd_ptr_angle, en_rd, en_modify_tw, en_modify,
      input  stage, busy, finish_FFT, out_valid, done_o
   );

   modport slave (
`ifdef FFT_SEQ_INVERSE_EN
      input  inverse,
`endif
      input  start, log2n, abort, en_out,
      output rd_ptr, rd_ptr_angle, en_rd, en_modify_tw, en_modify,
      output stage, busy, finish_FFT, out_valid, done_o
   );
endinterface

// File: rtl/fft_pipe_delay.sv
// -----------------------------------------------------------------------------
// fft_pipe_delay
//   1-bit delay line of DEPTH cycles (DEPTH >= 1).
//   clk     : clock
//   rst_n   : asynchronous active-low reset, clears the line
//   flush_i : synchronous clear of every stage
//   d_i     : input bit
//   q_o     : d_i delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module fft_pipe_delay #(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush_i,
   input  logic d_i,
   output logic q_o
);
   logic [DEPTH-1:0] sh_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q <= '0;
      end else if (flush_i) begin
         sh_q <= '0;
      end else begin
         sh_q <= (sh_q << 1) | DEPTH'(d_i);
      end
   end

   assign q_o = sh_q[DEPTH-1];
endmodule

// File: rtl/fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// fft_stage_sequencer
//   Runtime-length radix-2 DIT FFT sequencer. For N = 2^L (L latched on start)
//   it issues upper/lower butterfly reads per stage with twiddle indices,
//   delays the compute-read strobe by PIPE_LAT for RAM write-back, then
//   streams the result out in bit-reversed order paced by en_out.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : fft_stage_sequencer_if.slave
//                  in : start, log2n, abort, en_out [, inverse]
//                  out: rd_ptr, rd_ptr_angle, en_rd, en_modify_tw, en_modify,
//                       stage, busy, finish_FFT, out_valid, done_o
//   Optional macro FFT_SEQ_INVERSE_EN: adds 'inverse', negating twiddle angles.
// -----------------------------------------------------------------------------
module fft_stage_sequencer
   import fft_seq_pkg::*;
#(
   parameter int MAX_LOG2N = 10,
   parameter int PIPE_LAT  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fft_stage_sequencer_if.slave  bus
);
   localparam int              AW       = MAX_LOG2N;
   localparam int              GW       = 8;
   localparam logic [3:0]      MAX_L    = 4'(MAX_LOG2N);
   localparam logic [AW:0]     ONE_W    = (AW+1)'(1);
   localparam logic [AW-1:0]   ONE_A    = AW'(1);
   localparam logic [GW-1:0]   GAP_LAST = GW'(PIPE_LAT);

   seq_state_e    state_q, state_d;
   logic [3:0]    l_q, l_d;
   logic [3:0]    stage_q, stage_d;
   logic [AW-1:0] j_q, j_d;
   logic          half_q, half_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [AW-1:0] k_q, k_d;
   logic [AW-1:0] out_addr_q, out_addr_d;
   logic          out_valid_q, out_valid_d;
   logic          last_q, last_d;
   logic          done_q, done_d;
`ifdef FFT_SEQ_INVERSE_EN
   logic          inv_q, inv_d;
`endif

   logic [AW:0]      n_w, n_m1_w, half_m1_w, sbit_w, smask_w;
   logic [AW-1:0]    pos, upper, lower, ang_fwd, ang;
   logic [3:0]       ang_sh;
   logic [SEQ_W-1:0] br_w;
   logic             last_pair, last_k, last_stage, compute;
   logic             en_modify_tw;
   logic             unused_bits;

   // Butterfly addressing for the current pair j within stage s.
   assign n_w       = ONE_W << l_q;
   assign n_m1_w    = n_w - ONE_W;
   assign half_m1_w = (n_w >> 1) - ONE_W;
   assign sbit_w    = ONE_W << stage_q;
   assign smask_w   = sbit_w - ONE_W;
   assign pos       = j_q & smask_w[AW-1:0];
   assign upper     = ((j_q >> stage_q) << (stage_q + 4'd1)) | pos;
   assign lower     = upper | sbit_w[AW-1:0];

   // Twiddle index is scaled to the full-circle table, so it does not depend on N.
   assign ang_sh    = MAX_L - 4'd1 - stage_q;
   assign ang_fwd   = pos << ang_sh;
`ifdef FFT_SEQ_INVERSE_EN
   // Two's-complement negation gives (2^MAX - a) mod 2^MAX, leaving 0 at 0.
   assign ang       = inv_q ? ((~ang_fwd) + ONE_A) : ang_fwd;
`else
   assign ang       = ang_fwd;
`endif

   assign br_w       = bitrev(SEQ_W'(k_q), l_q);
   assign last_pair  = ({1'b0, j_q} == half_m1_w);
   assign last_k     = ({1'b0, k_q} == n_m1_w);
   assign last_stage = (stage_q == (l_q - 4'd1));
   assign compute    = (state_q == ST_COMPUTE);

   // Top bits of the wide helpers never reach an address output.
   assign unused_bits = ^{sbit_w[AW], smask_w[AW], br_w[SEQ_W-1:AW]};

   always_comb begin
      state_d     = state_q;
      l_d         = l_q;
      stage_d     = stage_q;
      j_d         = j_q;
      half_d      = half_q;
      gap_d       = gap_q;
      k_d         = k_q;
      out_addr_d  = out_addr_q;
      out_valid_d = 1'b0;
      last_d      = last_q;
      done_d      = 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
      inv_d       = inv_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_COMPUTE;
               l_d     = clamp_log2n(bus.log2n, MAX_L);
               stage_d = 4'd0;
               j_d     = '0;
               half_d  = 1'b0;
               gap_d   = '0;
               k_d     = '0;
               last_d  = 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
               inv_d   = bus.inverse;
`endif
            end
         end
         ST_COMPUTE: begin
            // Each pair takes two cycles: upper address, then lower.
            if (!half_q) begin
               half_d = 1'b1;
            end else begin
               half_d = 1'b0;
               if (last_pair) begin
                  j_d     = '0;
                  gap_d   = '0;
                  state_d = ST_GAP;
               end else begin
                  j_d = j_q + ONE_A;
               end
            end
         end
         ST_GAP: begin
            // PIPE_LAT+1 idle cycles let the last write-back land first.
            if (gap_q == GAP_LAST) begin
               gap_d = '0;
               if (last_stage) begin
                  state_d = ST_FINISH;
               end else begin
                  stage_d = stage_q + 4'd1;
                  state_d = ST_COMPUTE;
               end
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         ST_FINISH: begin
            state_d = ST_OUTPUT;
            k_d     = '0;
            last_d  = 1'b0;
         end
         ST_OUTPUT: begin
            // last_q marks the cycle the final address is on the bus.
            if (last_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               last_d  = 1'b0;
               k_d     = '0;
               stage_d = 4'd0;
            end else if (bus.en_out) begin
               out_valid_d = 1'b1;
               out_addr_d  = br_w[AW-1:0];
               if (last_k) begin
                  last_d = 1'b1;
               end else begin
                  k_d = k_q + ONE_A;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort overrides everything, including a simultaneous start.
      if (bus.abort) begin
         state_d     = ST_IDLE;
         stage_d     = 4'd0;
         j_d         = '0;
         half_d      = 1'b0;
         gap_d       = '0;
         k_d         = '0;
         last_d      = 1'b0;
         out_valid_d = 1'b0;
         done_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         l_q         <= 4'd0;
         stage_q     <= 4'd0;
         j_q         <= '0;
         half_q      <= 1'b0;
         gap_q       <= '0;
         k_q         <= '0;
         out_addr_q  <= '0;
         out_valid_q <= 1'b0;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         l_q         <= l_d;
         stage_q     <= stage_d;
         j_q         <= j_d;
         half_q      <= half_d;
         gap_q       <= gap_d;
         k_q         <= k_d;
         out_addr_q  <= out_addr_d;
         out_valid_q <= out_valid_d;
         last_q      <= last_d;
         done_q      <= done_d;
      end
   end

`ifdef FFT_SEQ_INVERSE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inv_q <= 1'b0;
      end else begin
         inv_q <= inv_d;
      end
   end
`endif

   assign en_modify_tw = compute;

   fft_pipe_delay #(
      .DEPTH (PIPE_LAT)
   ) u_wb_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (bus.abort),
      .d_i     (en_modify_tw),
      .q_o     (bus.en_modify)
   );

   assign bus.rd_ptr       = compute ? (half_q ? lower : upper)
                                     : (out_valid_q ? out_addr_q : '0);
   assign bus.rd_ptr_angle = compute ? ang : '0;
   assign bus.en_rd        = compute | out_valid_q;
   assign bus.en_modify_tw = en_modify_tw;
   assign bus.stage        = stage_q;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.finish_FFT   = (state_q == ST_FINISH);
   assign bus.out_valid    = out_valid_q;
   assign bus.done_o       = done_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
module tb_fft_stage_sequencer;
   localparam int MAXL = 10;
   localparam int PL   = 3;
   localparam int AW   = MAXL;
   localparam int TMAX = 16384;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_stage_sequencer_if #(.MAX_LOG2N(MAXL)) bus();

   fft_stage_sequencer #(
      .MAX_LOG2N (MAXL),
      .PIPE_LAT  (PL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic          busy;
      logic          en_rd;
      logic [AW-1:0] rd;
      logic [AW-1:0] ang;
      logic          tw;
      logic          md;
      logic          fin;
      logic          ov;
      logic          dn;
      logic [3:0]    stg;
   } obs_t;

   typedef struct {
      int run;
      int cyc;
      int rd;
      int ang;
      bit fin;
      bit ov;
      bit dn;
   } vec_t;

   obs_t expv[TMAX];
   obs_t actv[TMAX];
   logic eo[TMAX];
   vec_t tab[48];
   int   nt = 0;

   int errors = 0;
   int checks = 0;

   function automatic obs_t sample();
      obs_t o;
      o.busy  = bus.busy;
      o.en_rd = bus.en_rd;
      o.rd    = bus.rd_ptr;
      o.ang   = bus.rd_ptr_angle;
      o.tw    = bus.en_modify_tw;
      o.md    = bus.en_modify;
      o.fin   = bus.finish_FFT;
      o.ov    = bus.out_valid;
      o.dn    = bus.done_o;
      o.stg   = bus.stage;
      return o;
   endfunction

   task automatic chk(input string name, input int c, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h required %h", name, c, got, want);
      end
   endtask

   function automatic int brev(input int x, input int l);
      int r = 0;
      int v = x;
      for (int i = 0; i < l; i++) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return r;
   endfunction

   // Reference schedule: every cycle's outputs for one transform started at cycle 0.
   task automatic build_model(input int L, input bit inv, output int endc);
      int n, c, k, a, up, pos, p2s, f;
      for (int i = 0; i < TMAX; i++) expv[i] = '0;
      n = 1 << L;
      c = 1;
      for (int s = 0; s < L; s++) begin
         p2s = 1 << s;
         for (int j = 0; j < n / 2; j++) begin
            pos = j % p2s;
            up  = (j / p2s) * (2 * p2s) + pos;
            a   = pos * (1 << (MAXL - 1 - s));
            if (inv) a = ((1 << MAXL) - a) % (1 << MAXL);
            for (int h = 0; h < 2; h++) begin
               expv[c].busy  = 1'b1;
               expv[c].en_rd = 1'b1;
               expv[c].rd    = AW'(up + h * p2s);
               expv[c].ang   = AW'(a);
               expv[c].tw    = 1'b1;
               expv[c].stg   = 4'(s);
               c++;
            end
         end
         for (int g = 0; g < PL + 1; g++) begin
            expv[c].busy = 1'b1;
            expv[c].stg  = 4'(s);
            c++;
         end
      end
      f = c;
      expv[f].busy = 1'b1;
      expv[f].fin  = 1'b1;
      expv[f].stg  = 4'(L - 1);
      for (int i = 0; i < f; i++) if (expv[i].tw) expv[i + PL].md = 1'b1;
      k = 0;
      c = f + 1;
      while (k < n && c < TMAX - 4) begin
         expv[c].busy = 1'b1;
         expv[c].stg  = 4'(L - 1);
         if (eo[c]) begin
            expv[c + 1].ov    = 1'b1;
            expv[c + 1].en_rd = 1'b1;
            expv[c + 1].rd    = AW'(brev(k, L));
            k++;
         end
         c++;
      end
      expv[c].busy = 1'b1;
      expv[c].stg  = 4'(L - 1);
      expv[c + 1].dn = 1'b1;
      endc = c + 2;
   endtask

   task automatic run_seq(input int drv_l, input int L, input bit inv, input int mode,
                          input int extra_c, input string tag);
      int endc;
      for (int c = 0; c < TMAX; c++) begin
         case (mode)
            0:       eo[c] = 1'b1;
            1:       eo[c] = (c % 2 == 0);
            default: eo[c] = 1'($urandom_range(0, 1));
         endcase
      end
      build_model(L, inv, endc);
      for (int c = 0; c <= endc; c++) begin
         @(negedge clk);
         actv[c] = sample();
         chk(tag, c, 64'(actv[c]), 64'(expv[c]));
         bus.start  = (c == 0) || (c == extra_c);
         bus.log2n  = (c == 0) ? 4'(drv_l) : 4'd2;
         bus.en_out = eo[c];
`ifdef FFT_SEQ_INVERSE_EN
         bus.inverse = inv;
`endif
      end
      bus.start  = 1'b0;
      bus.en_out = 1'b0;
   endtask

   task automatic check_table(input int id);
      for (int i = 0; i < nt; i++) begin
         if (tab[i].run == id) begin
            chk($sformatf("vec%0d", i), tab[i].cyc,
                64'({actv[tab[i].cyc].rd, actv[tab[i].cyc].ang, actv[tab[i].cyc].fin,
                     actv[tab[i].cyc].ov, actv[tab[i].cyc].dn}),
                64'({AW'(tab[i].rd), AW'(tab[i].ang), tab[i].fin, tab[i].ov, tab[i].dn}));
         end
      end
   endtask

   task automatic addv(input int run, input int cyc, input int rd, input int ang,
                       input bit fin, input bit ov, input bit dn);
      tab[nt] = '{run, cyc, rd, ang, fin, ov, dn};
      nt++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t o;
      bit   any_fin, any_busy;
      int   rl, rd, rm;
      bit   rinv;

      // Run 0: L=4, en_out held high.
      addv(0, 1, 0, 0, 0, 0, 0);    addv(0, 2, 1, 0, 0, 0, 0);
      addv(0, 3, 2, 0, 0, 0, 0);    addv(0, 4, 3, 0, 0, 0, 0);
      addv(0, 16, 15, 0, 0, 0, 0);  addv(0, 21, 0, 0, 0, 0, 0);
      addv(0, 22, 2, 0, 0, 0, 0);   addv(0, 23, 1, 256, 0, 0, 0);
      addv(0, 24, 3, 256, 0, 0, 0); addv(0, 25, 4, 0, 0, 0, 0);
      addv(0, 26, 6, 0, 0, 0, 0);   addv(0, 27, 5, 256, 0, 0, 0);
      addv(0, 28, 7, 256, 0, 0, 0); addv(0, 61, 0, 0, 0, 0, 0);
      addv(0, 62, 8, 0, 0, 0, 0);   addv(0, 63, 1, 64, 0, 0, 0);
      addv(0, 64, 9, 64, 0, 0, 0);  addv(0, 81, 0, 0, 1, 0, 0);
      addv(0, 83, 0, 0, 0, 1, 0);   addv(0, 84, 8, 0, 0, 1, 0);
      addv(0, 85, 4, 0, 0, 1, 0);   addv(0, 86, 12, 0, 0, 1, 0);
      addv(0, 87, 2, 0, 0, 1, 0);   addv(0, 88, 10, 0, 0, 1, 0);
      addv(0, 89, 6, 0, 0, 1, 0);   addv(0, 90, 14, 0, 0, 1, 0);
      addv(0, 91, 1, 0, 0, 1, 0);   addv(0, 98, 15, 0, 0, 1, 0);
      addv(0, 99, 0, 0, 0, 0, 1);
      // Run 1: log2n=0 behaves as L=1.
      addv(1, 1, 0, 0, 0, 0, 0);    addv(1, 2, 1, 0, 0, 0, 0);
      addv(1, 7, 0, 0, 1, 0, 0);    addv(1, 9, 0, 0, 0, 1, 0);
      addv(1, 10, 1, 0, 0, 1, 0);   addv(1, 11, 0, 0, 0, 0, 1);
      // Run 2: log2n=15 behaves as L=10.
      addv(2, 10281, 0, 0, 1, 0, 0);

      bus.start  = 1'b0;
      bus.log2n  = 4'd0;
      bus.abort  = 1'b0;
      bus.en_out = 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
      bus.inverse = 1'b0;
`endif

      @(negedge clk);
      chk("reset_state", 0, 64'(sample()), 64'(0));
      rst_n = 1'b1;

      run_seq(4, 4, 1'b0, 0, 10, "L4_held");
      check_table(0);
      run_seq(0, 1, 1'b0, 0, -1, "L0_clamp");
      check_table(1);
      run_seq(15, 10, 1'b0, 0, -1, "L15_clamp");
      check_table(2);
      run_seq(4, 4, 1'b0, 1, 5, "L4_toggle");

      for (int r = 0; r < 5; r++) begin
         rl   = $urandom_range(1, 6);
         rd   = (rl == 1 && $urandom_range(0, 1) == 1) ? 0 : rl;
         rm   = $urandom_range(0, 2);
         rinv = 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
         rinv = 1'($urandom_range(0, 1));
`endif
         run_seq(rd, rl, rinv, rm, $urandom_range(2, 8), $sformatf("rand%0d", r));
      end

`ifdef FFT_SEQ_INVERSE_EN
      run_seq(4, 4, 1'b1, 0, -1, "L4_inverse");
`endif

      // Abort during stage 2 (reads span cycles 41..56 for L=4).
      any_fin  = 1'b0;
      any_busy = 1'b0;
      for (int c = 0; c <= 90; c++) begin
         @(negedge clk);
         o = sample();
         if (c == 46) chk("abort_pre", c, 64'({o.busy, o.md, o.stg}), 64'({1'b1, 1'b1, 4'd2}));
         if (c == 47) chk("abort_next", c, 64'({o.busy, o.md, o.en_rd, o.stg}), 64'(0));
         if (c >= 47) begin
            any_fin  = any_fin | o.fin | o.dn;
            any_busy = any_busy | o.busy | o.md;
         end
         bus.start  = (c == 0);
         bus.log2n  = 4'd4;
         bus.abort  = (c == 46);
         bus.en_out = 1'b1;
      end
      chk("abort_no_finish", 90, 64'({any_fin, any_busy}), 64'(0));

      // start together with abort in IDLE: abort wins.
      @(negedge clk);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("start_abort_idle", 0, 64'(sample()), 64'(0));

      // Asynchronous reset mid-compute clears all outputs at once.
      @(negedge clk);
      bus.start = 1'b1;
      bus.log2n = 4'd4;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (29) @(negedge clk);
      chk("pre_reset_busy", 30, 64'(sample().busy), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("async_reset", 30, 64'(sample()), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_reset_idle", 36, 64'(sample()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Runtime-length successor to the fixed-size FFT control block. It sequences in-place radix-2 DIT butterfly reads for every stage of an N-point FFT, where N = 2^log2n is chosen per transform up to 2^MAX_LOG2N. It generates twiddle indices and delayed write-back enables. It then streams the result out in bit-reversed order under `en_out` pacing. It sits between the sample RAM/butterfly datapath and the UART/output formatter.

## Interface
- `MAX_LOG2N`, 10: largest supported log2 length; twiddle table holds 2^MAX_LOG2N entries (full circle).
- `PIPE_LAT`, 3: read-to-write-back latency of the butterfly path, in cycles.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: start pulse; ignored unless IDLE.
- `log2n` in 4: transform length, latched on accepted `start`.
- `abort` in 1: synchronous abort; returns to IDLE next cycle.
- `en_out` in 1: output-phase advance; one address per high cycle.
- `rd_ptr` out MAX_LOG2N: RAM read address.
- `rd_ptr_angle` out MAX_LOG2N: twiddle ROM index.
- `en_rd` out 1: `rd_ptr` valid this cycle (compute or output).
- `en_modify_tw` out 1: compute-phase read active (twiddle fetch).
- `en_modify` out 1: `en_modify_tw` delayed PIPE_LAT cycles (RAM write-back).
- `stage` out 4: current stage index.
- `busy` out 1: not IDLE.
- `finish_FFT` out 1: one-cycle pulse, last stage write-back complete.
- `out_valid` out 1: output-phase read issued.
- `done_o` out 1: one-cycle pulse after last output read.

## Operation
- States: IDLE → COMPUTE → GAP → (COMPUTE | FINISH) → OUTPUT → IDLE.
- Clamp `log2n` on latch: 0 → 1; values above MAX_LOG2N → MAX_LOG2N. N = 2^L.
- COMPUTE stage s: pair counter j = 0..N/2−1; pos = j & (2^s−1); upper = ((j>>s)<<(s+1)) | pos; lower = upper + 2^s.
  - Issue upper, then lower, on consecutive cycles.
  - `rd_ptr_angle` = pos << (MAX_LOG2N−1−s), held for both reads. This index is independent of N.
- GAP: PIPE_LAT+1 idle cycles so the last write-back lands before the next stage reads. Then s increments, or FINISH after s = L−1.
- FINISH: one cycle, `finish_FFT` = 1.
- OUTPUT: counter k = 0..N−1 advances only on `en_out`.
  - `rd_ptr` = bit-reverse of k over L bits; `en_rd` = `out_valid` = 1 on those cycles.
  - After k = N−1 is issued, `done_o` pulses the next cycle and the state returns to IDLE.
- `rd_ptr` upper bits above L are zero.
- `abort` or reset mid-operation: counters cleared, no `finish_FFT`/`done_o`, delay line flushed.
- `start` together with `abort` in IDLE: `abort` wins.

## Timing
- Reset values: all outputs 0; state IDLE; `stage` 0.
- `start` accepted at cycle t → first `en_rd` at t+1 with `rd_ptr` = 0.
- Each stage occupies N read cycles plus PIPE_LAT+1 gap cycles.
- `finish_FFT` at t+1+L·(N+PIPE_LAT+1).
- `en_modify` at cycle c iff `en_modify_tw` at c−PIPE_LAT; it is not cleared by the GAP state, only by reset/abort.
- Output latency: `en_out` high at cycle c → `rd_ptr`/`out_valid` registered at c+1.

## Configuration
- `FFT_SEQ_INVERSE_EN` defined: adds input `inverse` (1 bit), latched on `start`. When latched high, `rd_ptr_angle` = (2^MAX_LOG2N − a) mod 2^MAX_LOG2N, so 0 stays 0 (IFFT twiddles).
- Not defined: no `inverse` port; angles are always forward.

## Structure
- Package `fft_seq_pkg`: state enum, `clamp_log2n` function, `bitrev` function parameterised by L.
- Sub-module `fft_pipe_delay` (1-bit, depth PIPE_LAT, async reset, synchronous flush) generates `en_modify`.

## Test plan
- L=4, MAX=10, PIPE_LAT=3, `start` at cycle 0:
  - Stage 0 addresses 0,1,2,3,…,15 with angles all 0.
  - Stage 1 addresses 0,2,1,3,4,6,5,7,… with angles 0,0,256,256,….
  - Stage 3 addresses 0,8,1,9,… with angles 0,0,64,64,….
  - `finish_FFT` at cycle 81.
- Output phase, L=4, `en_out` held high: `rd_ptr` = 0,8,4,12,2,10,6,14,1,… over 16 cycles; `done_o` one cycle after the 16th.
- `en_out` toggling 1/0: exactly one `out_valid` per high cycle; the address sequence is unchanged; no reads while low.
- `log2n`=0 → behaves as L=1 (reads 0,1; `finish_FFT` at cycle 7). `log2n`=15 → behaves as L=10.
- `abort` during stage 2 → IDLE next cycle, `en_modify` low within 1 cycle, no `finish_FFT`. `start` during `busy` is ignored.
- With `FFT_SEQ_INVERSE_EN`, L=4, `inverse`=1: stage 1 angles 0,0,768,768; stage 3 angles 0,0,960,960.
